// File: rtl/datapath.sv
// datapath -- single-cycle MIPS32 subset processor core.
//
// One instruction retires on every rising clk edge while rst is low. Fetch,
// decode, ALU and data-memory read are all combinational; the PC, register
// file, data memory and instruction memory update on the rising edge.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset (pc and registers to 0)
//   prog_we         instruction-memory write enable for program loading
//   prog_addr       instruction-memory word address for loading
//   prog_data       instruction word to load
//   out             ALU result of the current instruction
//   instruction     instruction word fetched at pc
//   opcode          instruction[31:26]
//   write_address   destination register of the current write, 0 if none
//   write_material  data written to the register file, 0 if none
//   pc              current program counter (byte address)
module datapath #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  output logic [31:0]                   out,
  output logic [31:0]                   instruction,
  output logic [5:0]                    opcode,
  output logic [4:0]                    write_address,
  output logic [31:0]                   write_material,
  output logic [31:0]                   pc
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];

  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] sext_imm, zext_imm, br_off;
  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_res, wr_data, pc_plus4, next_pc;
  logic [4:0]  dst;
  logic        reg_we, mem_rd, mem_wr, taken, jump, write_active;

  // pc[1:0] is ignored and the word index wraps modulo the memory depth.
  assign instruction = imem[pc[IAW+1:2]];
  assign opcode      = instruction[31:26];
  assign rs          = instruction[25:21];
  assign rt          = instruction[20:16];
  assign rd          = instruction[15:11];
  assign shamt       = instruction[10:6];
  assign funct       = instruction[5:0];
  assign imm         = instruction[15:0];

  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'b0, imm};
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};

  // $0 is hard-wired to zero on both read ports.
  assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];

  always_comb begin
    alu_res = 32'd0;
    dst     = rt;
    reg_we  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    taken   = 1'b0;
    jump    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dst = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  alu_res = rs_val + rt_val;
          FN_SUB:  alu_res = rs_val - rt_val;
          FN_AND:  alu_res = rs_val & rt_val;
          FN_OR:   alu_res = rs_val | rt_val;
          FN_NOR:  alu_res = ~(rs_val | rt_val);
          FN_SLT:  alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
          FN_SLL:  alu_res = rt_val << shamt;
          FN_SRL:  alu_res = rt_val >> shamt;
          default: reg_we = 1'b0;  // unknown funct is a NOP
        endcase
      end
      OP_ADDI: begin
        alu_res = rs_val + sext_imm;
        reg_we  = 1'b1;
      end
      OP_ANDI: begin
        alu_res = rs_val & zext_imm;
        reg_we  = 1'b1;
      end
      OP_ORI: begin
        alu_res = rs_val | zext_imm;
        reg_we  = 1'b1;
      end
      OP_SLTI: begin
        alu_res = {31'b0, $signed(rs_val) < $signed(sext_imm)};
        reg_we  = 1'b1;
      end
      OP_LUI: begin
        alu_res = {imm, 16'b0};
        reg_we  = 1'b1;
      end
      OP_LW: begin
        alu_res = rs_val + sext_imm;
        reg_we  = 1'b1;
        mem_rd  = 1'b1;
      end
      OP_SW: begin
        alu_res = rs_val + sext_imm;
        mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        alu_res = rs_val - rt_val;
        taken   = (rs_val == rt_val);
      end
      OP_BNE: begin
        alu_res = rs_val - rt_val;
        taken   = (rs_val != rt_val);
      end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  assign wr_data      = mem_rd ? dmem[alu_res[DAW+1:2]] : alu_res;
  assign write_active = reg_we && (dst != 5'd0);

  assign out            = alu_res;
  assign write_address  = write_active ? dst : 5'd0;
  assign write_material = write_active ? wr_data : 32'd0;

  assign pc_plus4 = pc + 32'd4;
  assign next_pc  = jump  ? {pc_plus4[31:28], instruction[25:0], 2'b00} :
                    taken ? pc_plus4 + br_off : pc_plus4;

  // Program loading works even while the core is held in reset.
  always_ff @(posedge clk) begin
    if (prog_we) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_wr) dmem[alu_res[DAW+1:2]] <= rt_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (write_active) regs[dst] <= wr_data;
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  localparam int NPROG = 26;
  localparam int NSTEP = 23;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] out, instruction, write_material, pc;
  logic [5:0]  opcode;
  logic [4:0]  write_address;

  int checks = 0;
  int errors = 0;

  datapath #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .out(out), .instruction(instruction),
    .opcode(opcode), .write_address(write_address),
    .write_material(write_material), .pc(pc)
  );

  always #5 clk = ~clk;

  logic [31:0] image [NPROG] = '{
    32'h20010005,  // 00 addi $1,$0,5
    32'h20020007,  // 04 addi $2,$0,7
    32'h00221820,  // 08 add  $3,$1,$2
    32'hAC030008,  // 0C sw   $3,8($0)
    32'h8C040008,  // 10 lw   $4,8($0)
    32'h10210002,  // 14 beq  $1,$1,+2 -> 0x20
    32'h20090001,  // 18 skipped
    32'h20090001,  // 1C skipped
    32'h14210002,  // 20 bne  $1,$1,+2 (not taken)
    32'h00222822,  // 24 sub  $5,$1,$2
    32'h0022302A,  // 28 slt  $6,$1,$2
    32'h3C071234,  // 2C lui  $7,0x1234
    32'h20000009,  // 30 addi $0,$0,9
    32'h00014025,  // 34 or   $8,$0,$1
    32'h000150C0,  // 38 sll  $10,$1,3
    32'h00055842,  // 3C srl  $11,$5,1
    32'h00226027,  // 40 nor  $12,$1,$2
    32'h08000014,  // 44 j    0x50
    32'h20090001,  // 48 skipped
    32'h20090001,  // 4C skipped
    32'h0000003F,  // 50 unsupported funct
    32'h30ADFFFF,  // 54 andi $13,$5,0xFFFF
    32'h28AE0000,  // 58 slti $14,$5,0
    32'h340F8001,  // 5C ori  $15,$0,0x8001
    32'h2010FFFF,  // 60 addi $16,$0,-1
    32'h1000FFFF   // 64 beq  $0,$0,-1 (spin)
  };

  logic [31:0] exp_pc [NSTEP] = '{
    32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h24,
    32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44,
    32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h64, 32'h64
  };
  logic [31:0] exp_out [NSTEP] = '{
    32'd5, 32'd7, 32'd12, 32'd8, 32'd8, 32'd0, 32'd0, 32'hFFFFFFFE,
    32'd1, 32'h12340000, 32'd9, 32'd5, 32'h28, 32'h7FFFFFFF, 32'hFFFFFFF8, 32'd0,
    32'd0, 32'h0000FFFE, 32'd1, 32'h8001, 32'hFFFFFFFF, 32'd0, 32'd0
  };
  logic [4:0] exp_wa [NSTEP] = '{
    5'd1, 5'd2, 5'd3, 5'd0, 5'd4, 5'd0, 5'd0, 5'd5,
    5'd6, 5'd7, 5'd0, 5'd8, 5'd10, 5'd11, 5'd12, 5'd0,
    5'd0, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd0
  };
  logic [31:0] exp_wm [NSTEP] = '{
    32'd5, 32'd7, 32'd12, 32'd0, 32'd12, 32'd0, 32'd0, 32'hFFFFFFFE,
    32'd1, 32'h12340000, 32'd0, 32'd5, 32'h28, 32'h7FFFFFFF, 32'hFFFFFFF8, 32'd0,
    32'd0, 32'h0000FFFE, 32'd1, 32'h8001, 32'hFFFFFFFF, 32'd0, 32'd0
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks the combinational view of the instruction at pc, then lets one edge pass.
  task automatic step(input string name, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_out, input logic [4:0] e_wa, input logic [31:0] e_wm);
    check({name, ".pc"}, pc, e_pc);
    check({name, ".instr"}, instruction, e_instr);
    check({name, ".opcode"}, {26'b0, opcode}, {26'b0, e_instr[31:26]});
    check({name, ".out"}, out, e_out);
    check({name, ".wa"}, {27'b0, write_address}, {27'b0, e_wa});
    check({name, ".wm"}, write_material, e_wm);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] e_instr;
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = 8'd0;
    prog_data = 32'd0;

    // Load the program while held in reset.
    for (int i = 0; i < NPROG; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 8'(i);
      prog_data = image[i];
    end
    @(negedge clk);
    prog_we = 1'b0;

    check("reset.pc", pc, 32'd0);
    check("reset.instr", instruction, 32'h20010005);
    rst = 1'b0;

    for (int s = 0; s < NSTEP; s++) begin
      e_instr = image[exp_pc[s][6:2]];
      step($sformatf("s%0d", s), exp_pc[s], e_instr, exp_out[s], exp_wa[s], exp_wm[s]);
    end

    // Mid-program reset: patch word 1 to read $5|$16, both nonzero before reset.
    rst       = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 8'd1;
    prog_data = 32'h00B08825;  // or $17,$5,$16
    @(negedge clk);
    prog_we = 1'b0;
    check("rst2.pc", pc, 32'd0);
    rst = 1'b0;
    step("r0", 32'h00, 32'h20010005, 32'd5, 5'd1, 32'd5);
    step("r1", 32'h04, 32'h00B08825, 32'd0, 5'd17, 32'd0);
    step("r2", 32'h08, 32'h00221820, 32'd5, 5'd3, 32'd5);  // $2 cleared by reset
    check("r3.pc", pc, 32'h0C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameter IMEM_WORDS, default 256, instruction memory depth in 32-bit words (power of 2).
REQ-002 Parameter DMEM_WORDS, default 256, data memory depth in 32-bit words (power of 2).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port prog_we  input  1  instruction-memory write enable, for program loading.
REQ-006 Port prog_addr  input  log2(IMEM_WORDS)  instruction-memory word address for loading.
REQ-007 Port prog_data  input  32  instruction word to load.
REQ-008 Port out  output  32  ALU result of the current instruction.
REQ-009 Port instruction  output  32  instruction word currently fetched at PC.
REQ-010 Port opcode  output  6  instruction[31:26].
REQ-011 Port write_address  output  5  destination register of the current instruction; 0 when no write.
REQ-012 Port write_material  output  32  data to be written to the register file; 0 when no write.
REQ-013 Port pc  output  32  current program counter (byte address).

Function
REQ-014 Single-cycle MIPS32 subset: one instruction completes per clk rising edge while rst=0.
REQ-015 Fetch is combinational: instruction = imem[pc[log2(IMEM_WORDS)+1:2]]; pc[1:0] ignored; index wraps modulo depth.
REQ-016 prog_we=1 writes prog_data to imem[prog_addr] on the rising edge, regardless of rst.
REQ-017 Register file: 32x32, two combinational read ports (rs, rt), one write port at the rising edge; $0 reads 0 always and is never written.
REQ-018 R-type (opcode 000000), by funct: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010 (signed), sll 000000 (rt << shamt), srl 000010 (logical); destination rd.
REQ-019 I-type: addi 001000 (sign-ext imm), andi 001100 / ori 001101 (zero-ext imm), slti 001010 (signed), lui 001111 (imm<<16); destination rt.
REQ-020 lw 100011: rt <= dmem[(rs+sext(imm))>>2]; sw 101011: dmem[(rs+sext(imm))>>2] <= rt at the rising edge; dmem index wraps modulo DMEM_WORDS.
REQ-021 beq 000100 / bne 000101: if taken, next pc = pc+4+(sext(imm)<<2); else pc+4.
REQ-022 j 000010: next pc = {(pc+4)[31:28], target, 2'b00}.
REQ-023 All other instructions: pc+4 otherwise no state change; add/addi/sub overflow wraps silently, no exception.
REQ-024 Unsupported funct under opcode 000000 behaves as NOP.
REQ-025 out = ALU result (address for lw/sw, rs-rt for branches, 0 for j/NOP).
REQ-026 write_material = loaded word for lw, else ALU result, when a register write occurs; writes with destination 0 report write_address=0, write_material=0.
REQ-027 dmem is not initialised; reading an unwritten location returns an undefined value.

Reset
REQ-028 rst=1 at rising edge: pc <= 0, all 32 registers <= 0; no register or dmem write that cycle.
REQ-029 imem and dmem contents are not cleared by reset.
REQ-030 First instruction executes on the first rising edge with rst=0, fetched from imem[0].

Verification
REQ-031 Load addi $1,$0,5 (0x20010005), addi $2,$0,7 (0x20020007), add $3,$1,$2 (0x00221820); run 3 cycles -> write_address 1/2/3, write_material 5/7/12, pc 0x0C.
REQ-032 sw $3,8($0) then lw $4,8($0) -> out=8 both cycles; second cycle write_address=4, write_material=12.
REQ-033 beq $1,$1,+2 at pc 0x10 -> next pc 0x1C; bne $1,$1,+2 -> next pc 0x14.
REQ-034 addi $0,$0,9 -> write_address=0, write_material=0; $0 still reads 0.
REQ-035 sub $5,$1,$2 with $1=5,$2=7 -> 0xFFFFFFFE; slt $6,$1,$2 -> 1; lui $7,0x1234 -> 0x12340000.
REQ-036 Assert rst mid-program -> next edge pc=0, registers zero, program re-executes from imem[0].
